axil_timer_irq: RTL and testbench

// - AXI4-Lite slave timer peripheral on the CPU's AXI-Lite port (0x4xxx_xxxx window).
// - Consumes the M_AXIL_* transactions the CPU wrapper issues.
// - Produces the irq level that feeds the wrapper's irq input.
// - 32-bit up-counter, optional prescaler, compare match, sticky pending flag (W1C), maskable interrupt.

---
 rtl/axil_timer_irq.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_axil_timer_irq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_timer_irq.sv
// -----------------------------------------------------------------------------
// axil_timer_irq
//
// AXI4-Lite slave timer peripheral. It provides a 32-bit up-counter, an
// optional prescaler, a compare match, a sticky pending flag (write-1-to-clear)
// and a maskable, registered interrupt level.
//
// Configuration macro:
//   TIMER_PRESCALER_EN - when defined, the PRESCALE register and the prescale
//                        counter are built. When undefined, the timer ticks on
//                        every enabled cycle, PRESCALE reads 0, and writes to
//                        PRESCALE are accepted with an OKAY response and ignored.
//
// Parameters:
//   AW      - AXI-Lite address width. Only addr[4:2] is decoded. AW must be
//             greater than 5.
//   RST_CMP - reset value of the COMPARE register.
//
// Ports:
//   clk_i, rst_i        - clock (rising edge); asynchronous, active-high reset
//   S_AXIL_AW*          - write address channel (AWADDR, AWVALID, AWREADY)
//   S_AXIL_W*           - write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_AXIL_B*           - write response channel (BRESP, BVALID, BREADY)
//   S_AXIL_AR*          - read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXIL_R*           - read data channel (RDATA, RRESP, RVALID, RREADY)
//   irq_o               - interrupt level, registered copy of pend & ie
//
// Register map (addr[4:2]):
//   0 CTRL     [0] en, [1] autoreload, [2] ie
//   1 STATUS   [0] pend (write 1 to clear)
//   2 COUNT    32-bit read/write
//   3 COMPARE  32-bit read/write
//   4 PRESCALE [15:0] read/write
//   5-7        read as 0; writes are ignored
// -----------------------------------------------------------------------------
`ifndef AW_AXIL
`define AW_AXIL 32
`endif

module axil_timer_irq #(
  parameter int          AW      = `AW_AXIL,
  parameter logic [31:0] RST_CMP = 32'hFFFF_FFFF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // write address channel
  input  logic [AW-1:0] S_AXIL_AWADDR,
  input  logic          S_AXIL_AWVALID,
  output logic          S_AXIL_AWREADY,
  // write data channel
  input  logic [31:0]   S_AXIL_WDATA,
  input  logic [3:0]    S_AXIL_WSTRB,
  input  logic          S_AXIL_WVALID,
  output logic          S_AXIL_WREADY,
  // write response channel
  output logic [1:0]    S_AXIL_BRESP,
  output logic          S_AXIL_BVALID,
  input  logic          S_AXIL_BREADY,
  // read address channel
  input  logic [AW-1:0] S_AXIL_ARADDR,
  input  logic          S_AXIL_ARVALID,
  output logic          S_AXIL_ARREADY,
  // read data channel
  output logic [31:0]   S_AXIL_RDATA,
  output logic [1:0]    S_AXIL_RRESP,
  output logic          S_AXIL_RVALID,
  input  logic          S_AXIL_RREADY,
  // interrupt
  output logic          irq_o
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_STATUS   = 3'd1;
  localparam logic [2:0] A_COUNT    = 3'd2;
  localparam logic [2:0] A_COMPARE  = 3'd3;
  localparam logic [2:0] A_PRESCALE = 3'd4;

  // Byte-lane merge: only the lanes enabled in strb take the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        aw_full_q, aw_full_d;
  logic [2:0]  aw_sel_q,  aw_sel_d;
  logic        w_full_q,  w_full_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        bvalid_q,  bvalid_d;

  logic        rvalid_q,  rvalid_d;
  logic [31:0] rdata_q,   rdata_d;

  logic        en_q, en_d;
  logic        ar_q, ar_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic        aw_hs, w_hs, wr_commit;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_ctrl, wr_status, wr_count, wr_compare, wr_prescale;

  // No new beat is taken while a response is outstanding.
  assign S_AXIL_AWREADY = ~aw_full_q & ~bvalid_q;
  assign S_AXIL_WREADY  = ~w_full_q  & ~bvalid_q;

  assign aw_hs = S_AXIL_AWVALID & S_AXIL_AWREADY;
  assign w_hs  = S_AXIL_WVALID  & S_AXIL_WREADY;

  // A half is available either from its holding register or from a handshake
  // happening this cycle, so the write commits as soon as the later half lands.
  assign wr_commit = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wr_sel    = aw_full_q ? aw_sel_q : S_AXIL_AWADDR[4:2];
  assign wr_data   = w_full_q  ? wdata_q  : S_AXIL_WDATA;
  assign wr_strb   = w_full_q  ? wstrb_q  : S_AXIL_WSTRB;

  assign wr_ctrl     = wr_commit & (wr_sel == A_CTRL);
  assign wr_status   = wr_commit & (wr_sel == A_STATUS);
  assign wr_count    = wr_commit & (wr_sel == A_COUNT);
  assign wr_compare  = wr_commit & (wr_sel == A_COMPARE);
  assign wr_prescale = wr_commit & (wr_sel == A_PRESCALE);

  always_comb begin
    aw_full_d = aw_full_q;
    aw_sel_d  = aw_sel_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_sel_d  = S_AXIL_AWADDR[4:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = S_AXIL_WDATA;
      wstrb_d  = S_AXIL_WSTRB;
    end

    if (wr_commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && S_AXIL_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  assign S_AXIL_BVALID = bvalid_q;
  assign S_AXIL_BRESP  = 2'b00;

  // ---------------------------------------------------------------------------
  // Tick generation
  // ---------------------------------------------------------------------------
  logic        tick;
  logic [31:0] prescale_rd;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] psc_cnt_q,  psc_cnt_d;

  // The prescale counter runs 0..PRESCALE; the tick fires on the last value.
  assign tick        = en_q & (psc_cnt_q == prescale_q);
  assign prescale_rd = {16'h0000, prescale_q};

  always_comb begin
    prescale_d = prescale_q;
    if (wr_prescale) begin
      if (wr_strb[0]) prescale_d[7:0]  = wr_data[7:0];
      if (wr_strb[1]) prescale_d[15:8] = wr_data[15:8];
    end

    psc_cnt_d = psc_cnt_q;
    if (en_q) psc_cnt_d = tick ? 16'h0000 : psc_cnt_q + 16'h0001;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescale_q <= 16'h0000;
      psc_cnt_q  <= 16'h0000;
    end else begin
      prescale_q <= prescale_d;
      psc_cnt_q  <= psc_cnt_d;
    end
  end
`else
  // Without a prescaler every enabled cycle is a tick; PRESCALE writes are
  // acknowledged but have no storage behind them.
  logic unused_prescale_wr;
  assign unused_prescale_wr = wr_prescale;
  assign tick               = en_q;
  assign prescale_rd        = 32'h0000_0000;
`endif

  // ---------------------------------------------------------------------------
  // Timer registers
  // ---------------------------------------------------------------------------
  logic count_match;
  assign count_match = (count_q == compare_q);

  always_comb begin
    en_d      = en_q;
    ar_d      = ar_q;
    ie_d      = ie_q;
    pend_d    = pend_q;
    count_d   = count_q;
    compare_d = compare_q;

    if (wr_ctrl && wr_strb[0]) begin
      en_d = wr_data[0];
      ar_d = wr_data[1];
      ie_d = wr_data[2];
    end

    if (wr_compare) compare_d = merge_bytes(compare_q, wr_data, wr_strb);

    // Software write to COUNT wins over the tick update of the same cycle.
    if (wr_count) begin
      count_d = merge_bytes(count_q, wr_data, wr_strb);
    end else if (tick) begin
      count_d = (ar_q && count_match) ? 32'h0000_0000 : count_q + 32'd1;
    end

    // Hardware set is applied after the W1C so that it wins a same-cycle race.
    if (wr_status && wr_strb[0] && wr_data[0]) pend_d = 1'b0;
    if (tick && count_match)                   pend_d = 1'b1;
  end

  // irq is built from registered sources only, so it trails pend/ie by a cycle.
  assign irq_d = pend_q & ie_q;
  assign irq_o = irq_q;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic        ar_hs;
  logic [31:0] rd_mux;

  assign S_AXIL_ARREADY = ~rvalid_q;
  assign ar_hs          = S_AXIL_ARVALID & S_AXIL_ARREADY;

  // Reads sample the current registers, so a read in a commit cycle returns
  // the value from before the write.
  always_comb begin
    rd_mux = 32'h0000_0000;
    case (S_AXIL_ARADDR[4:2])
      A_CTRL:     rd_mux = {29'h0, ie_q, ar_q, en_q};
      A_STATUS:   rd_mux = {31'h0, pend_q};
      A_COUNT:    rd_mux = count_q;
      A_COMPARE:  rd_mux = compare_q;
      A_PRESCALE: rd_mux = prescale_rd;
      default:    rd_mux = 32'h0000_0000;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && S_AXIL_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  assign S_AXIL_RVALID = rvalid_q;
  assign S_AXIL_RDATA  = rdata_q;
  assign S_AXIL_RRESP  = 2'b00;

  // Only addr[4:2] is decoded; the remaining address bits are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXIL_AWADDR[AW-1:5], S_AXIL_AWADDR[1:0],
                              S_AXIL_ARADDR[AW-1:5], S_AXIL_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      aw_sel_q  <= 3'd0;
      w_full_q  <= 1'b0;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      count_q   <= 32'h0000_0000;
      compare_q <= RST_CMP;
      irq_q     <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_sel_q  <= aw_sel_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      en_q      <= en_d;
      ar_q      <= ar_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_axil_timer_irq.sv
// -----------------------------------------------------------------------------
// tb_axil_timer_irq
//
// Directed bench for axil_timer_irq. All bus activity is driven and sampled on
// the falling clock edge; the DUT acts on the rising edge. Expected values are
// hand-computed from the cycle on which each write commits (the rising edge of
// its last handshake) and on which each read address is accepted.
// -----------------------------------------------------------------------------
module tb_axil_timer_irq;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;

  always #5 clk = ~clk;

  axil_timer_irq #(.AW(AW), .RST_CMP(32'hFFFF_FFFF)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .S_AXIL_AWADDR  (awaddr),
    .S_AXIL_AWVALID (awvalid),
    .S_AXIL_AWREADY (awready),
    .S_AXIL_WDATA   (wdata),
    .S_AXIL_WSTRB   (wstrb),
    .S_AXIL_WVALID  (wvalid),
    .S_AXIL_WREADY  (wready),
    .S_AXIL_BRESP   (bresp),
    .S_AXIL_BVALID  (bvalid),
    .S_AXIL_BREADY  (bready),
    .S_AXIL_ARADDR  (araddr),
    .S_AXIL_ARVALID (arvalid),
    .S_AXIL_ARREADY (arready),
    .S_AXIL_RDATA   (rdata),
    .S_AXIL_RRESP   (rresp),
    .S_AXIL_RVALID  (rvalid),
    .S_AXIL_RREADY  (rready),
    .irq_o          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full write: both halves together, then a B handshake. Commits on the first
  // rising edge after the call and returns one falling edge after the B beat.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bit aw_hs;
    bit w_hs;
    awaddr  = {24'h0, addr};
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_bresp", 32'({bvalid, bresp}), 32'h4);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("WR addr=%h data=%h strb=%b", addr, data, strb);
  endtask

  // Read: AR accepted on the next rising edge, data collected one edge later.
  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    int n;
    araddr  = {24'h0, addr};
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_rresp", 32'({rvalid, rresp}), 32'h4);
    data   = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    $display("RD addr=%h data=%h", addr, data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // ---- reset / idle ----
    repeat (3) @(negedge clk);
    check("rst_ready", 32'({arready, awready, wready}), 32'h7);
    check("rst_valid", 32'({bvalid, rvalid, irq}), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'({arready, awready, wready}), 32'h7);
    check("idle_valid", 32'({bvalid, rvalid, irq}), 32'h0);
    axi_read(8'h0C, rd); check("rst_compare", rd, 32'hFFFF_FFFF);
    axi_read(8'h08, rd); check("rst_count",   rd, 32'h0);
    axi_read(8'h00, rd); check("rst_ctrl",    rd, 32'h0);
    axi_read(8'h10, rd); check("rst_prescale", rd, 32'h0);

    // ---- W one cycle before AW, partial strobe, BREADY held low ----
    wdata = 32'h0000_0010; wstrb = 4'b0011; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("w_only_ready", 32'({wready, awready, bvalid}), 32'h2);
    awaddr = 32'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("aw_bvalid", 32'({bvalid, awready, wready}), 32'h4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_hold", 32'({bvalid, awready, wready}), 32'h4);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", 32'({bvalid, awready, wready}), 32'h3);
    $display("WR addr=0c data=00000010 strb=0011 (W before AW)");
    axi_read(8'h0C, rd); check("compare_strb", rd, 32'hFFFF_0010);

    // ---- unmapped addresses ----
    axi_write(8'h14, 32'hDEAD_BEEF, 4'hF);
    axi_read(8'h14, rd); check("unmapped5", rd, 32'h0);
    axi_read(8'h18, rd); check("unmapped6", rd, 32'h0);

    // ---- match + autoreload + irq, then W1C ----
    axi_write(8'h0C, 32'd5, 4'hF);
    axi_write(8'h00, 32'h7, 4'hF);      // commit E0, returns after E1
    check("irq_pre", 32'(irq), 32'h0);
    repeat (5) @(negedge clk);          // after E6: pend set, irq not yet
    check("irq_lag", 32'(irq), 32'h0);
    @(negedge clk);                     // after E7
    check("irq_set", 32'(irq), 32'h1);
    axi_read(8'h08, rd); check("count_reload", rd, 32'd1);
    axi_write(8'h00, 32'h6, 4'hF);      // stop, keep ie
    axi_write(8'h04, 32'h1, 4'hF);      // W1C
    check("irq_w1c", 32'(irq), 32'h0);
    axi_read(8'h04, rd); check("status_w1c", rd, 32'h0);

    // ---- W1C in the same cycle as a match tick ----
    axi_write(8'h08, 32'h0, 4'hF);      // C
    axi_write(8'h00, 32'h7, 4'hF);      // C+2, count=5 before C+8
    axi_write(8'h1C, 32'h0, 4'hF);      // C+4
    axi_write(8'h1C, 32'h0, 4'hF);      // C+6
    axi_write(8'h04, 32'h1, 4'hF);      // C+8, races the match
    check("race_irq", 32'(irq), 32'h1);
    axi_read(8'h04, rd); check("race_pend", rd, 32'h1);
    axi_write(8'h00, 32'h0, 4'hF);
    axi_write(8'h04, 32'h1, 4'hF);
    axi_read(8'h04, rd); check("race_clear", rd, 32'h0);
    check("race_irq_off", 32'(irq), 32'h0);

    // ---- COUNT wrap, pend on the following tick ----
    axi_write(8'h08, 32'hFFFF_FFFF, 4'hF);
    axi_write(8'h0C, 32'h0, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);      // C: wraps at C+1, matches at C+2
    axi_read(8'h04, rd); check("wrap_noflag", rd, 32'h0);
    axi_read(8'h08, rd); check("wrap_count",  rd, 32'd2);
    axi_read(8'h04, rd); check("wrap_pend",   rd, 32'h1);
    check("wrap_irq_masked", 32'(irq), 32'h0);
    axi_write(8'h00, 32'h0, 4'hF);
    axi_write(8'h04, 32'h1, 4'hF);

    // ---- concurrent read/write, read held with RREADY low ----
    axi_write(8'h08, 32'h1234_5678, 4'hF);
    araddr = 32'h08; arvalid = 1'b1;
    awaddr = 32'h08; wdata = 32'hA5A5_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("conc_rdata", rdata, 32'h1234_5678);
    check("conc_valid", 32'({rvalid, bvalid, arready}), 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("r_hold_data", rdata, 32'h1234_5678);
      check("r_hold_ready", 32'({rvalid, arready}), 32'h2);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    check("r_release", 32'({rvalid, arready, bvalid}), 32'h2);
    $display("RD addr=08 data=12345678 (concurrent with WR data=a5a50000)");
    axi_read(8'h08, rd); check("conc_newcount", rd, 32'hA5A5_0000);

    // ---- prescaler ----
`ifdef TIMER_PRESCALER_EN
    axi_write(8'h10, 32'h0001_0003, 4'hF);
    axi_read(8'h10, rd); check("prescale_rd", rd, 32'h3);
    axi_write(8'h0C, 32'h1, 4'hF);
    axi_write(8'h08, 32'h0, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);      // C: ticks at C+4, C+8, C+12
    axi_read(8'h08, rd); check("psc_c2",  rd, 32'd0);
    axi_read(8'h08, rd); check("psc_c4",  rd, 32'd0);
    axi_read(8'h08, rd); check("psc_c6",  rd, 32'd1);
    axi_read(8'h04, rd); check("psc_p8",  rd, 32'h0);
    axi_read(8'h04, rd); check("psc_p10", rd, 32'h1);
    axi_read(8'h08, rd); check("psc_c12", rd, 32'd2);
    check("psc_irq_masked", 32'(irq), 32'h0);
`else
    axi_write(8'h10, 32'h0000_0003, 4'hF);
    axi_read(8'h10, rd); check("prescale_ignored", rd, 32'h0);
    axi_write(8'h0C, 32'h1, 4'hF);
    axi_write(8'h08, 32'h0, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);      // C: tick every cycle, match at C+2
    axi_read(8'h08, rd); check("nopsc_count", rd, 32'd1);
    axi_read(8'h04, rd); check("nopsc_pend",  rd, 32'h1);
    check("nopsc_irq_masked", 32'(irq), 32'h0);
`endif

    // ---- reset while responses are pending ----
    awaddr = 32'h0C; wdata = 32'h0000_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h00; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_valid", 32'({bvalid, rvalid}), 32'h3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'({bvalid, rvalid, irq}), 32'h0);
    check("async_rst_ready", 32'({arready, awready, wready}), 32'h7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_read(8'h0C, rd); check("post_rst_compare", rd, 32'hFFFF_FFFF);
    axi_read(8'h04, rd); check("post_rst_status",  rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
